prod_accumulator: RTL and testbench

Downstream consumer of the 2x2 half-adder multiplier. It takes the multiplier's 4-bit product stream over a valid/ready handshake and sums groups of N_TERMS products (or shorter groups ended by in_last) into an ACC_W-bit result. Each result is presented on a valid/ready output port together with its term count, an overflow flag and an error flag. Together with the multiplier it forms a small dot-product / MAC path.

---
 rtl/prod_accumulator.sv | 132 +++++++++++++
 tb/tb_prod_accumulator.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums groups of 2x2-multiplier products into a saturating
// ACC_W-bit result. A group closes after N_TERMS accepted products or on an
// accepted beat carrying in_last. Each result waits in HOLD until the
// downstream takes it.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    product handshake (in_ready is high only in ACCUM)
//   in_prod[3:0]         unsigned product {c2,s2,s1,s0}
//   in_last              accepted beat closes the current group early
//   out_valid/out_ready  result handshake
//   out_sum[ACC_W-1:0]   saturated group sum
//   out_count[CNT_W-1:0] products in the group (1..N_TERMS)
//   out_ovf              sum saturated somewhere in the group
//   out_err              some product in the group exceeded 9
module prod_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int unsigned SUM_W    = ACC_W + 1;
  localparam int unsigned PROD_W   = 4;
  localparam int unsigned MAX_PROD = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             err_q;

  logic [SUM_W-1:0] sum_wide;
  logic             sat;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             err_nxt;
  logic             accept;
  logic             close;

  // Post-update values for the current beat; one extra sum bit detects saturation.
  always_comb begin
    sum_wide = '0;
    sat      = 1'b0;
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    ovf_nxt  = ovf_q;
    err_nxt  = err_q;
    accept   = 1'b0;
    close    = 1'b0;

    sum_wide = {1'b0, acc} + SUM_W'(in_prod);
    sat      = sum_wide[ACC_W];
    // acc is already at max once saturated, so a further add re-saturates.
    acc_nxt  = sat ? '1 : sum_wide[ACC_W-1:0];
    cnt_nxt  = cnt + CNT_W'(1);
    ovf_nxt  = ovf_q | sat;
    err_nxt  = err_q | (in_prod > PROD_W'(MAX_PROD));
    accept   = in_valid & in_ready;
    // in_last on the N-th beat is still one close.
    close    = (cnt == CNT_W'(N_TERMS - 1)) | in_last;
  end

  // Group FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf_q <= ovf_nxt;
            err_q <= err_nxt;
            if (close) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
              out_count <= cnt_nxt;
              out_ovf   <= ovf_nxt;
              out_err   <= err_nxt;
            end
          end
        end
        HOLD: begin
          // Result fields keep their values after the handshake.
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: two instances (ACC_W = 8 and ACC_W = 4) share
// the same stimulus and are checked against a group-level reference model.
module tb_prod_accumulator;

  localparam int unsigned N_TERMS = 4;
  localparam int unsigned CNT_W   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_last, out_ready;
  logic [3:0] in_prod;

  logic             in_ready_a, out_valid_a, ovf_a, err_a;
  logic [7:0]       sum_a;
  logic [CNT_W-1:0] cnt_a;
  logic             in_ready_b, out_valid_b, ovf_b, err_b;
  logic [3:0]       sum_b;
  logic [CNT_W-1:0] cnt_b;

  prod_accumulator #(.N_TERMS(N_TERMS), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(sum_a), .out_count(cnt_a),
    .out_ovf(ovf_a), .out_err(err_a)
  );

  prod_accumulator #(.N_TERMS(N_TERMS), .ACC_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(sum_b), .out_count(cnt_b),
    .out_ovf(ovf_b), .out_err(err_b)
  );

  logic [14:0] obs_a;
  logic [10:0] obs_b;
  assign obs_a = {out_valid_a, in_ready_a, sum_a, cnt_a, ovf_a, err_a};
  assign obs_b = {out_valid_b, in_ready_b, sum_b, cnt_b, ovf_b, err_b};

  // Reference model: the products of the open group, and the last result.
  int grp[$];
  bit m_hold;
  int e_sum_a, e_sum_b, e_cnt;
  bit e_ovf_a, e_ovf_b, e_err;

  int vectors;
  int miscompares;

  function automatic logic [14:0] exp_a();
    return {m_hold, ~m_hold, 8'(e_sum_a), CNT_W'(e_cnt), e_ovf_a, e_err};
  endfunction

  function automatic logic [10:0] exp_b();
    return {m_hold, ~m_hold, 4'(e_sum_b), CNT_W'(e_cnt), e_ovf_b, e_err};
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit v, l, r, ordy;
    int p;
    v = in_valid; l = in_last; r = rst; ordy = out_ready; p = int'(in_prod);
    @(posedge clk);
    #1;
    if (r) begin
      m_hold = 1'b0; grp.delete();
      e_sum_a = 0; e_sum_b = 0; e_cnt = 0; e_ovf_a = 0; e_ovf_b = 0; e_err = 0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        grp.delete();
      end
    end else if (v) begin
      grp.push_back(p);
      if (grp.size() == int'(N_TERMS) || l) begin
        int s;
        bit er;
        s = 0; er = 0;
        foreach (grp[i]) begin
          s += grp[i];
          if (grp[i] > 9) er = 1;
        end
        e_sum_a = (s > 255) ? 255 : s;
        e_ovf_a = (s > 255);
        e_sum_b = (s > 15) ? 15 : s;
        e_ovf_b = (s > 15);
        e_cnt   = grp.size();
        e_err   = er;
        m_hold  = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_prod = 4'd3; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (obs_a !== 15'b0100000_00000000 || obs_b !== 11'b01_0000_00000) begin
      miscompares++;
      $display("FAIL reset_state: a=%h b=%h, want a=%h b=%h", obs_a, obs_b,
               15'b0100000_00000000, 11'b01_0000_00000);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    vectors++;
    if (obs_a !== exp_a() || obs_b !== exp_b()) begin
      miscompares++;
      $display("FAIL reset_idle: a=%h want %h, b=%h want %h", obs_a, exp_a(), obs_b, exp_b());
    end
  endtask

  task automatic test_full_group();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = 4'd9; in_last = 1'b0;
      tick();
      vectors++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        miscompares++;
        $display("FAIL full_group beat %0d: a=%h want %h, b=%h want %h", i, obs_a, exp_a(), obs_b, exp_b());
      end
    end
    vectors++;
    if (out_valid_a !== 1'b1 || sum_a !== 8'd36 || cnt_a !== 3'd4 || ovf_a !== 1'b0 ||
        err_a !== 1'b0 || in_ready_a !== 1'b0) begin
      miscompares++;
      $display("FAIL full_group_result: got v=%b sum=%0d cnt=%0d ovf=%b err=%b rdy=%b, want 1 36 4 0 0 0",
               out_valid_a, sum_a, cnt_a, ovf_a, err_a, in_ready_a);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || obs_a !== exp_a()) begin
      miscompares++;
      $display("FAIL full_group_release: a=%h want %h", obs_a, exp_a());
    end
  endtask

  task automatic test_early_last();
    int prods[6] = '{6, 3, 1, 1, 1, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_prod = 4'(prods[i]); in_last = (i == 1);
      tick();
      vectors++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        miscompares++;
        $display("FAIL early_last beat %0d: a=%h want %h, b=%h want %h", i, obs_a, exp_a(), obs_b, exp_b());
      end
      if (i == 1) begin
        vectors++;
        if (out_valid_a !== 1'b1 || sum_a !== 8'd9 || cnt_a !== 3'd2) begin
          miscompares++;
          $display("FAIL early_last_result: got v=%b sum=%0d cnt=%0d, want 1 9 2", out_valid_a, sum_a, cnt_a);
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
      end
    end
    vectors++;
    if (out_valid_a !== 1'b1 || sum_a !== 8'd4 || cnt_a !== 3'd4 || err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_next_group: got v=%b sum=%0d cnt=%0d err=%b, want 1 4 4 0", out_valid_a, sum_a, cnt_a, err_a);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int prods[4] = '{9, 9, 0, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = 4'(prods[i]); in_last = 1'b0;
      tick();
      vectors++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        miscompares++;
        $display("FAIL overflow beat %0d: a=%h want %h, b=%h want %h", i, obs_a, exp_a(), obs_b, exp_b());
      end
    end
    vectors++;
    if (sum_b !== 4'd15 || ovf_b !== 1'b1 || cnt_b !== 3'd4 || sum_a !== 8'd18 || ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_result: got sum4=%0d ovf4=%b cnt4=%0d sum8=%0d ovf8=%b, want 15 1 4 18 0",
               sum_b, ovf_b, cnt_b, sum_a, ovf_a);
    end
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_prod = 4'd1; tick();
    in_last = 1'b1; tick();
    vectors++;
    if (out_valid_b !== 1'b1 || sum_b !== 4'd2 || ovf_b !== 1'b0 || cnt_b !== 3'd2) begin
      miscompares++;
      $display("FAIL overflow_cleared: got v=%b sum4=%0d ovf4=%b cnt4=%0d, want 1 2 0 2", out_valid_b, sum_b, ovf_b, cnt_b);
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
  endtask

  task automatic test_err_backpressure();
    int prods[4] = '{4, 15, 2, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = 4'(prods[i]); in_last = 1'b0;
      tick();
    end
    // Upstream offers 7 with in_last while the result is stalled.
    out_ready = 1'b0; in_prod = 4'd7; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || sum_a !== 8'd22 || err_a !== 1'b1 ||
          cnt_a !== 3'd4 || obs_a !== exp_a() || obs_b !== exp_b()) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: a=%h want %h (sum 22 err 1), b=%h want %h",
                 i, obs_a, exp_a(), obs_b, exp_b());
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (out_valid_a !== 1'b1 || sum_a !== 8'd7 || cnt_a !== 3'd1 || err_a !== 1'b0 || obs_a !== exp_a()) begin
      miscompares++;
      $display("FAIL held_beat_once: got v=%b sum=%0d cnt=%0d err=%b, want 1 7 1 0", out_valid_a, sum_a, cnt_a, err_a);
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
  endtask

  task automatic test_reset_midgroup();
    int prods[4] = '{1, 2, 3, 4};
    out_ready = 1'b1; in_last = 1'b0;
    in_valid = 1'b1; in_prod = 4'd5; tick(); tick();
    rst = 1'b1; in_valid = 1'b0; tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = 4'(prods[i]);
      tick();
    end
    vectors++;
    if (out_valid_a !== 1'b1 || sum_a !== 8'd10 || cnt_a !== 3'd4 || obs_a !== exp_a() || obs_b !== exp_b()) begin
      miscompares++;
      $display("FAIL reset_midgroup: got v=%b sum=%0d cnt=%0d, want 1 10 4", out_valid_a, sum_a, cnt_a);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 4'd2; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    vectors++;
    if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || sum_a !== 8'd2) begin
      miscompares++;
      $display("FAIL hold_before_reset: got v=%b rdy=%b sum=%0d, want 1 0 2", out_valid_a, in_ready_a, sum_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_valid_b !== 1'b0 || in_ready_b !== 1'b1 ||
        obs_a !== exp_a()) begin
      miscompares++;
      $display("FAIL reset_in_hold: got v=%b rdy=%b a=%h, want v=0 rdy=1 a=%h", out_valid_a, in_ready_a, obs_a, exp_a());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = 4'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      vectors++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        miscompares++;
        $display("FAIL random cycle %0d: a=%h want %h, b=%h want %h", i, obs_a, exp_a(), obs_b, exp_b());
      end
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_prod = 4'd0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_full_group();
    test_early_last();
    test_overflow();
    test_err_backpressure();
    test_reset_midgroup();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
